pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Next-PC sequencer between fetch, decode, the EX-stage branch predictor and the PC register. Each cycle it chooses the next PC from four sources: EX misprediction redirect, decode-stage jump, fetch-stage predicted-taken target, and sequential PC. It drives the pipeline-register flush lines and holds a redirect that cannot be applied while instruction memory is busy. It also keeps saturating branch and misprediction statistics.

## Interface
- WIDTH, 16, PC/address width
- CNT_WIDTH, 16, statistics counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- imem_ready  in  1  instruction memory can accept a new PC this cycle
- stall  in  1  hazard-unit stall; freezes the PC and IF/ID
- pc_seq  in  WIDTH  sequential next PC (current PC + 1)
- if_pred_taken  in  1  predictor hit with taken history for the fetching PC
- if_pred_target  in  WIDTH  predicted BTA
- id_jump  in  1  unconditional jump decoded in ID
- id_target  in  WIDTH  jump target
- ex_is_beq  in  1  branch instruction present in EX
- ex_change  in  1  misprediction detected in EX (predictor change_PC)
- ex_target  in  WIDTH  corrected PC from the predictor
- pc_next  out  WIDTH  value to load into the PC register
- pc_we  out  1  PC register load enable
- flush_ifid, flush_idrr, flush_rrex  out  1 each  synchronous clear of each pipeline register at the next edge
- redirect_busy  out  1  high in state PENDING
- branch_cnt  out  CNT_WIDTH  branches resolved in EX
- mispred_cnt  out  CNT_WIDTH  mispredictions resolved in EX

## Operation
- Registered state: FSM (IDLE, PENDING), pend_target[WIDTH], and the two counters. All other outputs are combinational from the inputs and registered state.
- Reset (rst=0, asynchronous): state=IDLE, pend_target=0, both counters=0. While rst=0, outputs are forced: pc_we=0, all three flushes=1, redirect_busy=0, pc_next=0.
- Source priority, highest first: ex_change, then id_jump, then if_pred_taken, then sequential.
- IDLE, ex_change=1:
  - flush_ifid, flush_idrr and flush_rrex all =1.
  - stall is ignored.
  - If imem_ready=1: pc_next=ex_target and pc_we=1.
  - Otherwise: pc_we=0, pend_target<=ex_target, next state PENDING.
- IDLE, ex_change=0, stall=1: pc_we=0, no flush, and id_jump/if_pred_taken are ignored. The stalled jump is presented again later.
- IDLE, id_jump=1, stall=0:
  - flush_ifid=1 only.
  - If imem_ready=1: pc_next=id_target and pc_we=1.
  - Otherwise: capture id_target into pend_target and go to PENDING.
- IDLE, if_pred_taken=1 (no higher source): pc_next=if_pred_target, pc_we=imem_ready, no flush, nothing captured.
- IDLE, sequential case: pc_next=pc_seq, pc_we=imem_ready.
- PENDING:
  - id_jump, if_pred_taken and stall are ignored; all flushes=0.
  - When imem_ready=1: pc_next=pend_target, pc_we=1, next state IDLE.
- PENDING, ex_change=1 (newer redirect):
  - All three flushes=1.
  - If imem_ready=1: apply ex_target directly and go to IDLE.
  - Otherwise: pend_target<=ex_target and stay in PENDING.
- Counters:
  - branch_cnt increments on every edge with ex_is_beq=1.
  - mispred_cnt increments on every edge with ex_change=1.
  - Both saturate at all-ones and never wrap.
  - ex_change=1 with ex_is_beq=0 still counts as a misprediction.
- pc_next is don't-care when pc_we=0. The implementation drives pc_seq in that case.

## Timing
- Redirect latency is zero cycles: the flush and pc_next are valid in the same cycle as ex_change or id_jump. The PC and pipeline registers take the new value at the next edge.
- A redirect that is blocked by imem_ready=0 is applied in the first cycle with imem_ready=1. It is never dropped.
- The flush for an EX redirect is asserted exactly once, in the detection cycle. It is not repeated when the pending target is applied.
- Counters are visible one edge after the qualifying cycle.
- If rst is asserted in PENDING, the held target is discarded and the FSM returns to IDLE.

## Test plan
- Reset: with rst=0 mid-PENDING (pend_target=0x0040), all flushes=1 and pc_we=0. After release: IDLE, counters 0, pc_next=pc_seq.
- Priority: in one cycle, ex_change=1 (ex_target=0x0020), id_jump=1 (0x0030), if_pred_taken=1 (0x0010), stall=1, imem_ready=1. Required: pc_next=0x0020, pc_we=1, all three flushes=1.
- Blocked redirect: ex_change=1 (ex_target=0x0055) with imem_ready=0 for 3 cycles. Required: redirect_busy=1, pc_we=0, flushes only in the first cycle. Then imem_ready=1 gives pc_next=0x0055, pc_we=1, IDLE next cycle.
- Jump and stall: id_jump=1 (0x0100) with stall=1 gives pc_we=0 and no flush. With stall=0 the next cycle: pc_next=0x0100 and flush_ifid=1 only.
- Overwrite in PENDING: pend_target=0x0070, then ex_change=1 (0x0080) with imem_ready=0. Later, imem_ready=1 gives pc_next=0x0080.
- Saturation: with CNT_WIDTH=4, hold ex_is_beq=1 and ex_change=1 for 20 cycles. Both counters stop at 0xF.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Next-PC sequencer. Each cycle selects the PC to load from, highest
//   priority first: EX misprediction redirect, ID jump, IF predicted-taken
//   target, then the sequential PC. It drives the pipeline-register flush
//   lines. A redirect that arrives while instruction memory is busy is held
//   in PENDING until memory is ready. Saturating counters track resolved
//   branches and mispredictions.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   imem_ready          instruction memory can accept a new PC this cycle
//   stall               hazard stall (freezes PC and IF/ID)
//   pc_seq              sequential next PC
//   if_pred_taken/_target   fetch-stage predicted-taken redirect
//   id_jump/id_target       decode-stage unconditional jump
//   ex_is_beq           branch resolved in EX
//   ex_change/ex_target EX misprediction redirect
//   pc_next, pc_we      PC register load value / enable
//   flush_ifid/idrr/rrex    synchronous clears for pipeline registers
//   redirect_busy       a held redirect is waiting for imem_ready
//   branch_cnt, mispred_cnt saturating statistics
module pc_redirect_ctrl #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_ready,
    input  logic                 stall,
    input  logic [WIDTH-1:0]     pc_seq,
    input  logic                 if_pred_taken,
    input  logic [WIDTH-1:0]     if_pred_target,
    input  logic                 id_jump,
    input  logic [WIDTH-1:0]     id_target,
    input  logic                 ex_is_beq,
    input  logic                 ex_change,
    input  logic [WIDTH-1:0]     ex_target,
    output logic [WIDTH-1:0]     pc_next,
    output logic                 pc_we,
    output logic                 flush_ifid,
    output logic                 flush_idrr,
    output logic                 flush_rrex,
    output logic                 redirect_busy,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pend_target, pend_target_nxt;

    // State register and held redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        pc_next         = pc_seq;
        pc_we           = 1'b0;
        flush_ifid      = 1'b0;
        flush_idrr      = 1'b0;
        flush_rrex      = 1'b0;
        redirect_busy   = (state == PENDING);

        unique case (state)
            IDLE: begin
                if (ex_change) begin
                    // Misprediction overrides stall and every younger source.
                    flush_ifid = 1'b1;
                    flush_idrr = 1'b1;
                    flush_rrex = 1'b1;
                    if (imem_ready) begin
                        pc_next = ex_target;
                        pc_we   = 1'b1;
                    end else begin
                        pend_target_nxt = ex_target;
                        state_nxt       = PENDING;
                    end
                end else if (stall) begin
                    // Frozen: a stalled jump is re-presented by decode later.
                    pc_we = 1'b0;
                end else if (id_jump) begin
                    flush_ifid = 1'b1;
                    if (imem_ready) begin
                        pc_next = id_target;
                        pc_we   = 1'b1;
                    end else begin
                        pend_target_nxt = id_target;
                        state_nxt       = PENDING;
                    end
                end else if (if_pred_taken) begin
                    if (imem_ready) begin
                        pc_next = if_pred_target;
                        pc_we   = 1'b1;
                    end
                end else begin
                    pc_we = imem_ready;
                end
            end

            PENDING: begin
                if (ex_change) begin
                    // Newer EX redirect replaces the held target and flushes
                    // once, in its own detection cycle.
                    flush_ifid = 1'b1;
                    flush_idrr = 1'b1;
                    flush_rrex = 1'b1;
                    if (imem_ready) begin
                        pc_next   = ex_target;
                        pc_we     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        pend_target_nxt = ex_target;
                    end
                end else if (imem_ready) begin
                    // Held redirect applied without repeating its flush.
                    pc_next   = pend_target;
                    pc_we     = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        // Reset holds the pipeline cleared and the PC register idle.
        if (!rst) begin
            pc_next       = '0;
            pc_we         = 1'b0;
            flush_ifid    = 1'b1;
            flush_idrr    = 1'b1;
            flush_rrex    = 1'b1;
            redirect_busy = 1'b0;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (ex_is_beq && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (ex_change && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
